// File: rtl/cordic_sequencer_if.sv
// Request/response handshake bundle for the CORDIC sequencer.
// The master side issues angle requests and consumes results.
// The slave side is the sequencer.
interface cordic_sequencer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_angle;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;

  modport master (
    output in_valid, in_angle, out_ready,
    input  in_ready, out_valid, out_x, out_y
  );

  modport slave (
    input  in_valid, in_angle, out_ready,
    output in_ready, out_valid, out_x, out_y
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Upstream controller for the CORDIC iteration core.
// Each request is handled in a fixed sequence of steps:
//   1. Fold the full-circle angle into the first quadrant.
//   2. Clear the core, then pulse calc ITERS times.
//   3. Capture the core's x/y result.
//   4. Rotate that result back into the original quadrant.
//   5. Hold the result on a valid/ready output until it is taken.
module cordic_sequencer #(
  parameter int ITERS = 8,
  parameter int W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_sequencer_if.slave    bus,
  output logic                 core_rst,
  output logic                 core_calc,
  output logic [W-1:0]         core_angle,
  input  logic [W-1:0]         core_x,
  input  logic [W-1:0]         core_y,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, OUT} state_t;

  localparam logic [3:0]   LAST  = 4'(ITERS - 1);
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [1:0]   q;
  logic         accept;
  logic [W-1:0] fix_x, fix_y;

  // Two's-complement negate.
  // The most negative value clamps to the most positive one instead of wrapping.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
    return (v == S_MIN) ? S_MAX : (W'(0) - v);
  endfunction

  assign accept = bus.in_valid && (state == IDLE);

  // State register.
  // rst aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and combinational handshake/core controls.
  // During rst the core is held in reset and calc is masked.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    busy         = 1'b1;
    core_rst     = rst;
    core_calc    = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        core_rst  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        core_calc = !rst;
        if (cnt == LAST) state_nxt = SETTLE;
      end
      SETTLE: state_nxt = OUT;
      OUT: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rotate the first-quadrant core result back by q quarter turns.
  always_comb begin
    fix_x = core_x;
    fix_y = core_y;
    case (q)
      2'd0: begin fix_x = core_x;          fix_y = core_y;          end
      2'd1: begin fix_x = neg_sat(core_y); fix_y = core_x;          end
      2'd2: begin fix_x = neg_sat(core_x); fix_y = neg_sat(core_y); end
      2'd3: begin fix_x = core_y;          fix_y = neg_sat(core_x); end
      default: ;
    endcase
  end

  // Datapath registers.
  // This block holds:
  //  - the quadrant and folded angle latched on accept,
  //  - the iteration counter,
  //  - the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      q             <= '0;
      core_angle    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            q          <= bus.in_angle[W-1:W-2];
            core_angle <= {2'b00, bus.in_angle[W-3:0]};
          end
        end
        RUN: cnt <= cnt + 4'd1;
        SETTLE: begin
          bus.out_x     <= fix_x;
          bus.out_y     <= fix_y;
          bus.out_valid <= 1'b1;
        end
        OUT: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer.
// The bench contains a behavioural model of the iteration core.
// The core model presents the configured x/y only after exactly ITERS calc pulses since its last clear.
// Otherwise it presents a marker value.
module tb_cordic_sequencer;
  localparam int ITERS = 8;
  localparam int W     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_rst, core_calc, busy;
  logic [W-1:0]  core_angle, core_x, core_y;
  logic [W-1:0]  mcx = 16'h1000, mcy = 16'h0200;
  int            ccnt = 0;
  int            rst_cnt = 0, calc_cnt = 0;
  int            n_chk = 0, n_fail = 0;

  cordic_sequencer_if #(.W(W)) bus();

  cordic_sequencer #(.ITERS(ITERS), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_rst(core_rst), .core_calc(core_calc), .core_angle(core_angle),
    .core_x(core_x), .core_y(core_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model.
  assign core_x = (ccnt == ITERS) ? mcx : 16'h5A5A;
  assign core_y = (ccnt == ITERS) ? mcy : 16'hA5A5;

  always @(posedge clk) begin
    if (core_rst)       ccnt <= 0;
    else if (core_calc) ccnt <= ccnt + 1;
    if (core_rst && !rst) rst_cnt <= rst_cnt + 1;
    if (core_calc)        calc_cnt <= calc_cnt + 1;
  end

  typedef struct {
    logic [15:0] angle, cx, cy, eca, ex, ey;
  } vec_t;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Reference model.
  // Fold the angle, then rotate the ideal core result by a quarter turn per quadrant.
  // Clamp to 16 bits at the end.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] cx, input logic [15:0] cy,
                           output logic [15:0] eca, output logic [15:0] ex, output logic [15:0] ey);
    int quad, x, y, t;
    quad = int'(a) / 16384;
    eca  = 16'(int'(a) % 16384);
    x = int'($signed(cx));
    y = int'($signed(cy));
    repeat (quad) begin
      t = x; x = -y; y = t;
    end
    ex = sat16(x);
    ey = sat16(y);
  endtask

  // One full request.
  // The result is held for 'hold' cycles before out_ready rises.
  // A conflicting in_valid is offered during the hold.
  task automatic run_req(input logic [15:0] angle, input logic [15:0] eca,
                         input logic [15:0] ex, input logic [15:0] ey, input int hold);
    int lat, to, r0, c0;
    logic [15:0] ca0, ox, oy;
    logic ca_ok;
    to = 0;
    while (!bus.in_ready && to < 50) begin step(); to++; end
    chk("accept_wait_timeout", 32'(to < 50), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_angle = angle;
    r0 = rst_cnt;
    c0 = calc_cnt;
    step();
    bus.in_valid = 1'b0;
    ca0 = core_angle;
    ca_ok = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (core_angle !== ca0) ca_ok = 1'b0;
      step();
      lat++;
    end
    chk("core_angle", ca0, eca);
    chk("core_angle_stable", ca_ok, 1'b1);
    chk("latency", lat, ITERS + 2);
    chk("core_rst_pulses", rst_cnt - r0, 1);
    chk("core_calc_cycles", calc_cnt - c0, ITERS);
    chk("out_x", bus.out_x, ex);
    chk("out_y", bus.out_y, ey);
    ox = bus.out_x;
    oy = bus.out_y;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_angle = ~angle;
      step();
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_out_x", bus.out_x, ox);
      chk("hold_out_y", bus.out_y, oy);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] a, eca, ex, ey;
    logic seen;
    int cyc, na, nr;
    int acc[2];
    logic [15:0] rx[2], ry[2];

    tbl[0] = '{16'h1234, 16'h1000, 16'h0200, 16'h1234, 16'h1000, 16'h0200};
    tbl[1] = '{16'h4100, 16'h1000, 16'h0200, 16'h0100, 16'hFE00, 16'h1000};
    tbl[2] = '{16'h8123, 16'h1000, 16'h0200, 16'h0123, 16'hF000, 16'hFE00};
    tbl[3] = '{16'hC000, 16'h1000, 16'h0200, 16'h0000, 16'h0200, 16'hF000};
    tbl[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF};
    tbl[5] = '{16'h4000, 16'h8000, 16'h1234, 16'h0000, 16'hEDCC, 16'h8000};

    bus.in_valid  = 1'b0;
    bus.in_angle  = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    rst = 1'b1;
    step(); step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_x", bus.out_x, 16'h0);
    chk("rst_out_y", bus.out_y, 16'h0);
    chk("rst_core_angle", core_angle, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_calc", core_calc, 1'b0);
    chk("rst_core_rst", core_rst, 1'b1);
    rst = 1'b0;
    step();
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      mcx = tbl[i].cx;
      mcy = tbl[i].cy;
      run_req(tbl[i].angle, tbl[i].eca, tbl[i].ex, tbl[i].ey, 0);
    end

    // Backpressure: hold the result for 5 cycles.
    mcx = 16'h1000;
    mcy = 16'h0200;
    run_req(16'h8123, 16'h0123, 16'hF000, 16'hFE00, 5);

    // Randomized requests against the reference model.
    for (int i = 0; i < 20; i++) begin
      a   = 16'($urandom);
      mcx = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      mcy = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      ref_model(a, mcx, mcy, eca, ex, ey);
      run_req(a, eca, ex, ey, $urandom_range(0, 2));
    end

    // Reset abort during the 4th RUN cycle.
    mcx = 16'h1000;
    mcy = 16'h0200;
    bus.in_valid = 1'b1;
    bus.in_angle = 16'h4100;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("abort_calc_before", core_calc, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_core_calc", core_calc, 1'b0);
    chk("abort_core_rst", core_rst, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    seen = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    bus.out_ready = 1'b0;
    chk("abort_no_out_valid", seen, 1'b0);

    // Back-to-back requests with out_ready tied high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_angle  = 16'h1234;
    cyc = 0;
    na  = 0;
    nr  = 0;
    while (nr < 2 && cyc < 80) begin
      seen = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        rx[nr] = bus.out_x;
        ry[nr] = bus.out_y;
        nr++;
      end
      step();
      cyc++;
      if (seen) begin
        acc[na] = cyc;
        na++;
        if (na == 1) bus.in_angle = 16'h4100;
        else         bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results_seen", nr, 2);
    chk("b2b_accepts", na, 2);
    if (na == 2) chk("b2b_spacing", acc[1] - acc[0], ITERS + 4);
    if (nr == 2) begin
      chk("b2b_x0", rx[0], 16'h1000);
      chk("b2b_y0", ry[0], 16'h0200);
      chk("b2b_x1", rx[1], 16'hFE00);
      chk("b2b_y1", ry[1], 16'h1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
